// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding
// and default operand widths.
package div_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Default widths: 36-bit dividend/quotient, 9-bit divisor/remainder,
    // and an iteration counter wide enough to hold the dividend width.
    localparam int DEF_DIVIDEND_W = 36;
    localparam int DEF_DIVISOR_W  = 9;
    localparam int DEF_CNT_W      = 6;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, trial-subtract the divisor, and keep the difference when it does
// not borrow.
module div_step #(
    parameter int DIVISOR_W = 9
) (
    input  logic [DIVISOR_W:0]   pr_in,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_out,
    output logic                 q_bit
);

    // One guard bit above the partial remainder makes the borrow of the
    // trial subtraction directly visible as the MSB of the difference.
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    // Trial subtraction; a clear borrow bit means shifted >= divisor.
    always_comb begin
        shifted = {pr_in, dividend_bit};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[DIVISOR_W+1];
        pr_out  = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero reported in one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    div_state_e              state_q, state_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so one register serves as both the dividend and quotient shifter.
    logic [DIVIDEND_W-1:0]   sr_q, sr_d;
    logic [DIVISOR_W-1:0]    divisor_q, divisor_d;
    logic [DIVISOR_W:0]      pr_q, pr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
    logic                    dbz_q, dbz_d;

    logic [DIVISOR_W:0]      pr_next;
    logic                    q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr_in        (pr_q),
        .dividend_bit (sr_q[DIVIDEND_W-1]),
        .divisor      (divisor_q),
        .pr_out       (pr_next),
        .q_bit        (q_bit)
    );

    // Next-state and datapath updates; results change only on completion.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        divisor_d   = divisor_q;
        pr_d        = pr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        sr_d      = dividend;
                        divisor_d = divisor;
                        pr_d      = '0;
                        cnt_d     = CNT_W'(DIVIDEND_W);
                        state_d   = RUN;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                sr_d  = {sr_q[DIVIDEND_W-2:0], q_bit};
                pr_d  = pr_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = {sr_q[DIVIDEND_W-2:0], q_bit};
                    remainder_d = pr_next[DIVISOR_W-1:0];
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            divisor_q   <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            divisor_q   <= divisor_d;
            pr_q        <= pr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider with hand-computed expected results.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [35:0] dividend;
    logic [8:0]  divisor;
    logic        busy;
    logic        done;
    logic [35:0] quotient;
    logic [8:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps negedge by negedge until done, counting elapsed edges and busy
    // cycles; optionally scrambles the operand inputs while waiting.
    task automatic wait_done(output int cyc, output int bcnt, output bit both, input bit scramble);
        cyc  = 0;
        bcnt = 0;
        both = 1'b0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) bcnt++;
            if (busy === 1'b1 && done === 1'b1) both = 1'b1;
            if (scramble) begin
                dividend = {4'($urandom), 32'($urandom)};
                divisor  = 9'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        if (busy === 1'b1 && done === 1'b1) both = 1'b1;
    endtask

    task automatic do_op(input logic [35:0] a, input logic [8:0] b,
                         input logic [35:0] eq, input logic [8:0] er,
                         input logic edbz, input string tag);
        int  cyc;
        int  bcnt;
        bit  both;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt, both, 1'b0);
        chk(64'(cyc),  edbz ? 64'd0 : 64'd36, {tag, "_latency"});
        chk(64'(bcnt), edbz ? 64'd0 : 64'd36, {tag, "_busy_cycles"});
        chk(64'(both), 64'd0, {tag, "_busy_and_done"});
        chk(64'(quotient), 64'(eq), {tag, "_quotient"});
        chk(64'(remainder), 64'(er), {tag, "_remainder"});
        chk(64'(div_by_zero), 64'(edbz), {tag, "_dbz"});
        @(negedge clk);
        chk(64'(done), 64'd0, {tag, "_done_pulse"});
        chk(64'(quotient), 64'(eq), {tag, "_quotient_held"});
        $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b cycles=%0d",
                 tag, a, b, quotient, remainder, div_by_zero, cyc);
    endtask

    // Directed sequence: reset, arithmetic cases, handshake, reset mid-run.
    initial begin
        int cyc;
        int bcnt;
        bit both;
        bit saw_done;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        chk(64'(busy), 64'd0, "rst_busy");
        chk(64'(done), 64'd0, "rst_done");
        chk(64'(quotient), 64'd0, "rst_quotient");
        chk(64'(remainder), 64'd0, "rst_remainder");
        chk(64'(div_by_zero), 64'd0, "rst_dbz");
        @(negedge clk);
        rst = 1'b1;

        do_op(36'd1000, 9'd7, 36'd142, 9'd6, 1'b0, "basic");
        do_op(36'd123, 9'd0, 36'hFFFFFFFFF, 9'd0, 1'b1, "divzero");
        do_op(36'd3888, 9'd16, 36'd243, 9'd0, 1'b0, "chain");
        do_op(36'hFFFFFFFFF, 9'd511, 36'd134480385, 9'd0, 1'b0, "max_by_511");
        do_op(36'd68719476735, 9'd1, 36'd68719476735, 9'd0, 1'b0, "max_by_1");
        do_op(36'd5, 9'd9, 36'd0, 9'd5, 1'b0, "small");

        // start held high: only IDLE samples count, mid-run operands ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 36'd100;
        divisor  = 9'd3;
        @(negedge clk);
        wait_done(cyc, bcnt, both, 1'b1);
        chk(64'(cyc), 64'd36, "hold_a_latency");
        chk(64'(quotient), 64'd33, "hold_a_quotient");
        chk(64'(remainder), 64'd1, "hold_a_remainder");
        $display("op hold_a: 100 / 3 -> q=%0d r=%0d", quotient, remainder);
        dividend = 36'd200;
        divisor  = 9'd9;
        @(negedge clk);
        chk(64'(done), 64'd0, "hold_done_to_idle");
        chk(64'(busy), 64'd0, "hold_idle_not_busy");
        @(negedge clk);
        chk(64'(busy), 64'd1, "hold_b_accepted");
        chk(64'(quotient), 64'd33, "hold_results_stable");
        wait_done(cyc, bcnt, both, 1'b1);
        start = 1'b0;
        chk(64'(cyc), 64'd36, "hold_b_latency");
        chk(64'(quotient), 64'd22, "hold_b_quotient");
        chk(64'(remainder), 64'd2, "hold_b_remainder");
        $display("op hold_b: 200 / 9 -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);

        // asynchronous reset at iteration 10 of a run
        @(negedge clk);
        start    = 1'b1;
        dividend = 36'd1000;
        divisor  = 9'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk(64'(busy), 64'd0, "midrst_busy");
        chk(64'(done), 64'd0, "midrst_done");
        chk(64'(quotient), 64'd0, "midrst_quotient");
        chk(64'(remainder), 64'd0, "midrst_remainder");
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk(64'(saw_done), 64'd0, "midrst_no_resume");
        $display("op midrst: aborted run, activity after reset=%0b", saw_done);

        do_op(36'd3888, 9'd16, 36'd243, 9'd0, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
